// File: rtl/clock_time_core_if.sv
// Button inputs and display-facing outputs of the timekeeping core.
// The pm signal exists only when TWELVE_HOUR_EN is defined.
interface clock_time_core_if;
   logic       btn_mode;
   logic       btn_up;
   logic [3:0] digit3;
   logic [3:0] digit2;
   logic [3:0] digit1;
   logic [3:0] digit0;
   logic       sec_tick;
   logic       colon;
   logic [3:0] blink_mask;
`ifdef TWELVE_HOUR_EN
   logic       pm;
`endif

   // master: the clock core; slave: the button/display side
   modport master (
      input  btn_mode,
      input  btn_up,
      output digit3,
      output digit2,
      output digit1,
      output digit0,
      output sec_tick,
      output colon,
      output blink_mask
`ifdef TWELVE_HOUR_EN
      , output pm
`endif
   );

   modport slave (
      output btn_mode,
      output btn_up,
      input  digit3,
      input  digit2,
      input  digit1,
      input  digit0,
      input  sec_tick,
      input  colon,
      input  blink_mask
`ifdef TWELVE_HOUR_EN
      , input pm
`endif
   );
endinterface

// File: rtl/clock_time_core.sv
// BCD hh:mm:ss clock with 1 Hz prescaler, button-driven hour/minute setting and edit blink.
// Define TWELVE_HOUR_EN for 12-hour display (12,01..11) with a pm output.
module clock_time_core #(
   parameter int unsigned TICK_DIV  = 100000000,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input logic               clk,
   input logic               reset,
   clock_time_core_if.master bus
);
   localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned BLINK_W = $clog2(2 * BLINK_DIV);
   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_DIV);
`ifdef TWELVE_HOUR_EN
   localparam logic [7:0] HR_RESET = 8'h12;
`else
   localparam logic [7:0] HR_RESET = 8'h00;
`endif

   typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;

   state_t               state_q, state_d;
   logic [TICK_W-1:0]    presc_q, presc_d;
   logic [BLINK_W-1:0]   blink_q, blink_d;
   logic [7:0]           hr_q, hr_d, min_q, min_d, sec_q, sec_d;
   logic                 tick_q, tick_d, colon_q, colon_d;
   logic [3:0]           mask_q, mask_d;
   logic [1:0]           sync_mode_q, sync_up_q;
   logic                 edge_mode_q, edge_up_q;
   logic                 mode_pulse, up_pulse, tick_due, phase;
`ifdef TWELVE_HOUR_EN
   logic                 pm_q, pm_d;
`endif

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] hr_inc(input logic [7:0] v);
`ifdef TWELVE_HOUR_EN
      return (v == 8'h12) ? 8'h01 : bcd_inc(v);
`else
      return (v == 8'h23) ? 8'h00 : bcd_inc(v);
`endif
   endfunction

   assign mode_pulse = sync_mode_q[1] & ~edge_mode_q;
   assign up_pulse   = sync_up_q[1] & ~edge_up_q;
   assign tick_due   = (state_q == RUN) && (presc_q == TICK_LAST);

   // Next-state, time update and output decode; mode pulses take priority over up and tick
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      hr_d    = hr_q;
      min_d   = min_q;
      sec_d   = sec_q;
      tick_d  = 1'b0;
      colon_d = colon_q;
      mask_d  = 4'b0000;
      blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + BLINK_W'(1);
      if (mode_pulse) begin
         presc_d = '0;
         case (state_q)
            RUN: begin
               state_d = SET_HR;
               sec_d   = 8'h00;
            end
            SET_HR:  state_d = SET_MIN;
            default: state_d = RUN;
         endcase
      end else begin
         case (state_q)
            RUN: begin
               if (tick_due) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  colon_d = ~colon_q;
                  if (sec_q == 8'h59) begin
                     sec_d = 8'h00;
                     if (min_q == 8'h59) begin
                        min_d = 8'h00;
                        hr_d  = hr_inc(hr_q);
                     end else begin
                        min_d = bcd_inc(min_q);
                     end
                  end else begin
                     sec_d = bcd_inc(sec_q);
                  end
               end else begin
                  presc_d = presc_q + TICK_W'(1);
               end
            end
            SET_HR:  if (up_pulse) hr_d = hr_inc(hr_q);
            SET_MIN: if (up_pulse) min_d = (min_q == 8'h59) ? 8'h00 : bcd_inc(min_q);
            default: state_d = RUN;
         endcase
      end
      if (state_d != RUN) colon_d = 1'b1;
      phase = (blink_d >= BLINK_HALF);
      case (state_d)
         SET_HR:  mask_d = {phase, phase, 2'b00};
         SET_MIN: mask_d = {2'b00, phase, phase};
         default: mask_d = 4'b0000;
      endcase
`ifdef TWELVE_HOUR_EN
      // 11 -> 12 is reached only by increment, by tick carry or by the up button
      pm_d = ((hr_q == 8'h11) && (hr_d == 8'h12)) ? ~pm_q : pm_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= RUN;
         presc_q     <= '0;
         blink_q     <= '0;
         hr_q        <= HR_RESET;
         min_q       <= 8'h00;
         sec_q       <= 8'h00;
         tick_q      <= 1'b0;
         colon_q     <= 1'b0;
         mask_q      <= 4'b0000;
         sync_mode_q <= 2'b00;
         sync_up_q   <= 2'b00;
         edge_mode_q <= 1'b0;
         edge_up_q   <= 1'b0;
`ifdef TWELVE_HOUR_EN
         pm_q        <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         blink_q     <= blink_d;
         hr_q        <= hr_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         tick_q      <= tick_d;
         colon_q     <= colon_d;
         mask_q      <= mask_d;
         sync_mode_q <= {sync_mode_q[0], bus.btn_mode};
         sync_up_q   <= {sync_up_q[0], bus.btn_up};
         edge_mode_q <= sync_mode_q[1];
         edge_up_q   <= sync_up_q[1];
`ifdef TWELVE_HOUR_EN
         pm_q        <= pm_d;
`endif
      end
   end

   assign bus.digit3     = hr_q[7:4];
   assign bus.digit2     = hr_q[3:0];
   assign bus.digit1     = min_q[7:4];
   assign bus.digit0     = min_q[3:0];
   assign bus.sec_tick   = tick_q;
   assign bus.colon      = colon_q;
   assign bus.blink_mask = mask_q;
`ifdef TWELVE_HOUR_EN
   assign bus.pm         = pm_q;
`endif
endmodule
